// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive sequencer for the majority-filtered serial line.
// Finds the start bit, samples each data bit at mid-bit, checks the stop
// bit and hands finished bytes to the command parser over valid/ready.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_ctrl #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_BITS    = 8
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit          PARITY_ODD   = 1'b0
`endif
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_rx,
   input  logic                 i_ready,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_frame_err,
   output logic                 o_overrun,
`ifdef UART_RX_PARITY_EN
   output logic                 o_parity_err,
`endif
   output logic                 o_busy
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   state_t                 state;
   state_t                 state_nx;
   logic [CW-1:0]          cnt;
   logic [IW-1:0]          idx;
   logic [DATA_BITS-1:0]   shreg;

   logic                   sample;
   logic                   shift_en;
   logic                   deliver;
   logic                   frame_err;
   logic                   drop;

`ifdef UART_RX_PARITY_EN
   logic                   par_bit;
   logic                   par_en;
   logic                   par_bad;
`endif

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode and per-edge strobes for the datapath.
   always_comb begin
      state_nx  = state;
      sample    = 1'b0;
      shift_en  = 1'b0;
      deliver   = 1'b0;
      frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en    = 1'b0;
`endif
      unique case (state)
         S_IDLE: begin
            if (!i_rx) begin
               state_nx = S_START;
            end
         end
         S_START: begin
            if (cnt == CNT_HALF) begin
               sample   = 1'b1;
               state_nx = i_rx ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt == CNT_FULL) begin
               sample   = 1'b1;
               shift_en = 1'b1;
               if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_nx = S_PARITY;
`else
                  state_nx = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt == CNT_FULL) begin
               sample   = 1'b1;
               par_en   = 1'b1;
               state_nx = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cnt == CNT_FULL) begin
               sample = 1'b1;
               if (i_rx) begin
                  deliver  = 1'b1;
                  state_nx = S_IDLE;
               end else begin
                  frame_err = 1'b1;
                  state_nx  = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (i_rx) begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // A delivery is dropped only when the held byte is not being taken this edge.
   assign drop   = deliver && o_valid && !i_ready;
   assign o_busy = (state != S_IDLE);

`ifdef UART_RX_PARITY_EN
   assign par_bad = ((^shreg) ^ par_bit) != PARITY_ODD;
`endif

   // Bit-time counter: restarts on every state change and every sample.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= '0;
      end else if ((state_nx != state) || sample ||
                   (state == S_IDLE) || (state == S_BREAK)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Data bit index, reset whenever the next state is not DATA.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idx <= '0;
      end else if (state_nx != S_DATA) begin
         idx <= '0;
      end else if (shift_en) begin
         idx <= idx + 1'b1;
      end
   end

   // LSB-first shift register: new bit enters at the MSB.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         shreg <= '0;
      end else if (shift_en) begin
         shreg <= {i_rx, shreg[DATA_BITS-1:1]};
      end
   end

`ifdef UART_RX_PARITY_EN
   // Captured parity bit of the frame in progress.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         par_bit <= 1'b0;
      end else if (par_en) begin
         par_bit <= i_rx;
      end
   end
`endif

   // Error pulses last exactly one cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         o_frame_err <= frame_err;
         o_overrun   <= drop;
      end
   end

   // Output holding register and valid/ready handshake.
   // Acceptance and delivery on the same edge reload rather than clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data       <= '0;
         o_valid      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         o_parity_err <= 1'b0;
`endif
      end else if (deliver && !drop) begin
         o_data       <= shreg;
         o_valid      <= 1'b1;
`ifdef UART_RX_PARITY_EN
         o_parity_err <= par_bad;
`endif
      end else if (o_valid && i_ready) begin
         o_valid      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frames are driven bit by bit, outputs
// are sampled 1 ns after each rising edge and checked against hand values.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

   localparam int N  = 16;
   localparam int H  = N / 2;
   localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
   localparam int NB = DB + 3;
`else
   localparam int NB = DB + 2;
`endif
   localparam int FL        = NB * N;
   localparam int STOP_EDGE = H + (NB - 1) * N;

   logic          clk;
   logic          rst_n;
   logic          rx;
   logic          ready;
   logic [DB-1:0] data;
   logic          valid;
   logic          ferr;
   logic          ovr;
   logic          busy;
`ifdef UART_RX_PARITY_EN
   logic          perr;
`endif

   int n_cmp = 0;
   int n_err = 0;

   int cyc = 0;
   int base = 0;
   int n_valid, n_ferr, n_ovr, n_busy;
   int first_valid, ferr_edge, ovr_edge, last_busy;
   logic [DB-1:0] cap_data, stop_data;
   logic          stop_valid, post_valid;
`ifdef UART_RX_PARITY_EN
   logic          stop_perr;
`endif

   uart_rx_ctrl #(
      .CLKS_PER_BIT(N),
      .DATA_BITS(DB)
`ifdef UART_RX_PARITY_EN
      ,
      .PARITY_ODD(1'b0)
`endif
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_rx(rx),
      .i_ready(ready),
      .o_data(data),
      .o_valid(valid),
      .o_frame_err(ferr),
      .o_overrun(ovr),
`ifdef UART_RX_PARITY_EN
      .o_parity_err(perr),
`endif
      .o_busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      base        = cyc;
      n_valid     = 0;
      n_ferr      = 0;
      n_ovr       = 0;
      n_busy      = 0;
      first_valid = -1;
      ferr_edge   = -1;
      ovr_edge    = -1;
      last_busy   = -1;
      cap_data    = '0;
      stop_data   = '0;
      stop_valid  = 1'b0;
      post_valid  = 1'b1;
`ifdef UART_RX_PARITY_EN
      stop_perr   = 1'b0;
`endif
   endtask

   // One clock; edge number is relative to the last clr().
   task automatic tick();
      int e;
      @(posedge clk);
      #1;
      cyc++;
      e = cyc - base - 1;
      if (valid) begin
         n_valid++;
         if (first_valid < 0) begin
            first_valid = e;
            cap_data    = data;
         end
      end
      if (ferr) begin
         n_ferr++;
         ferr_edge = e;
      end
      if (ovr) begin
         n_ovr++;
         ovr_edge = e;
      end
      if (busy) begin
         n_busy++;
         last_busy = e;
      end
      if (e == STOP_EDGE) begin
         stop_valid = valid;
         stop_data  = data;
`ifdef UART_RX_PARITY_EN
         stop_perr  = perr;
`endif
      end
      if (e == STOP_EDGE + 1) post_valid = valid;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                             input int rdy_edge);
      logic [10:0] frm;
`ifdef UART_RX_PARITY_EN
      frm = {stop, par, d, 1'b0};
`else
      frm = {par, stop, d, 1'b0};
`endif
      for (int b = 0; b < NB; b++) begin
         rx = frm[b];
         for (int k = 0; k < N; k++) begin
            tick();
            if (b * N + k == rdy_edge) ready = 1'b1;
         end
      end
      rx = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      rx    = 1'b1;
      ready = 1'b0;
      clr();
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", valid, 0);
      check("rst_data",  data,  0);
      check("rst_ferr",  ferr,  0);
      check("rst_ovr",   ovr,   0);
      check("rst_busy",  busy,  0);
      rst_n = 1'b1;
      repeat (3) tick();

      // Clean byte with consumer ready.
      ready = 1'b1;
      clr();
      send_frame(8'hA5, 1'b1, 1'b0, -1);
      repeat (5) tick();
      check("a5_first_edge", first_valid, STOP_EDGE);
      check("a5_valid_cycles", n_valid, 1);
      check("a5_data", cap_data, 8'hA5);
      check("a5_stop_valid", stop_valid, 1);
      check("a5_post_valid", post_valid, 0);
      check("a5_ferr", n_ferr, 0);
      check("a5_ovr", n_ovr, 0);
      check("a5_busy_end", busy, 0);

      // Short low glitch rejected at the start-bit sample.
      clr();
      rx = 1'b0;
      repeat (5) tick();
      rx = 1'b1;
      repeat (20) tick();
      check("glitch_busy_cycles", n_busy, H);
      check("glitch_last_busy", last_busy, H - 1);
      check("glitch_valid", n_valid, 0);
      check("glitch_busy_end", busy, 0);

      // Framing error, held break, then a good byte.
      clr();
      send_frame(8'h3C, 1'b0, 1'b0, -1);
      rx = 1'b0;
      repeat (40) tick();
      check("ferr_count", n_ferr, 1);
      check("ferr_edge", ferr_edge, STOP_EDGE);
      check("ferr_no_valid", n_valid, 0);
      check("ferr_busy_break", busy, 1);
      rx = 1'b1;
      repeat (2) tick();
      check("ferr_busy_idle", busy, 0);
      clr();
      send_frame(8'h55, 1'b1, 1'b0, -1);
      repeat (5) tick();
      check("after_ferr_edge", first_valid, STOP_EDGE);
      check("after_ferr_data", cap_data, 8'h55);
      check("after_ferr_ferr", n_ferr, 0);

      // Overrun: consumer stalled across two back-to-back frames.
      ready = 1'b0;
      clr();
      send_frame(8'h11, 1'b1, 1'b0, -1);
      send_frame(8'h22, 1'b1, 1'b0, -1);
      repeat (4) tick();
      check("ovr_first_edge", first_valid, STOP_EDGE);
      check("ovr_first_data", cap_data, 8'h11);
      check("ovr_count", n_ovr, 1);
      check("ovr_edge", ovr_edge, FL + STOP_EDGE);
      check("ovr_held_valid", valid, 1);
      check("ovr_held_data", data, 8'h11);
      ready = 1'b1;
      tick();
      check("ovr_accept_valid", valid, 0);
      ready = 1'b0;

      // Accept of a held byte on the same edge a new one lands.
      clr();
      send_frame(8'h33, 1'b1, 1'b0, -1);
      repeat (3) tick();
      check("sim_held_data", data, 8'h33);
      clr();
      send_frame(8'h44, 1'b1, 1'b0, STOP_EDGE - 1);
      repeat (3) tick();
      check("sim_stop_valid", stop_valid, 1);
      check("sim_stop_data", stop_data, 8'h44);
      check("sim_ovr", n_ovr, 0);
      check("sim_post_valid", post_valid, 0);
      ready = 1'b0;

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x07 has three ones.
      ready = 1'b1;
      clr();
      send_frame(8'h07, 1'b1, 1'b0, -1);
      repeat (3) tick();
      check("par0_valid", stop_valid, 1);
      check("par0_data", stop_data, 8'h07);
      check("par0_perr", stop_perr, 1);
      clr();
      send_frame(8'h07, 1'b1, 1'b1, -1);
      repeat (3) tick();
      check("par1_valid", stop_valid, 1);
      check("par1_data", stop_data, 8'h07);
      check("par1_perr", stop_perr, 0);
      ready = 1'b0;
`endif

      // Asynchronous reset mid-frame with a byte still held.
      clr();
      send_frame(8'h5A, 1'b1, 1'b0, -1);
      repeat (3) tick();
      check("pre_rst_data", data, 8'h5A);
      clr();
      rx = 1'b0;
      repeat (61) tick();
      check("pre_rst_busy", busy, 1);
      check("pre_rst_valid", valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", valid, 0);
      check("mid_rst_data", data, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ferr", ferr, 0);
      check("mid_rst_ovr", ovr, 0);
      rx = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      clr();
      repeat (200) tick();
      check("post_rst_valid", n_valid, 0);
      check("post_rst_busy", n_busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the serial input after the 3-tap majority filter. Detects the start bit, times and samples each data bit at mid-bit, checks the stop bit and delivers bytes over a valid/ready handshake. The filter output (already synchronised and de-glitched) drives i_rx directly. Sits between the filtered RX pin and the co-processor command parser.

Parameters:
CLKS_PER_BIT, 16, i_clk cycles per serial bit (N); must be >= 4 and even; H = N/2.
DATA_BITS, 8, data bits per frame, sent LSB first.

Ports:
i_clk  input  1  system clock.
i_rst_n  input  1  one clock; reset is asynchronous and active-low.
i_rx  input  1  filtered serial line; idle high.
i_ready  input  1  consumer accepts o_data when high with o_valid.
o_data  output  DATA_BITS  received byte; stable while o_valid=1.
o_valid  output  1  byte available; held until accepted.
o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
o_overrun  output  1  one-cycle pulse: byte completed while previous byte unaccepted.
o_busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, counters 0, o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0; applies immediately mid-frame; partial byte discarded.
- Bit counter cnt: width clog2(N), cleared on every state change and on every sample; bit index idx: width clog2(DATA_BITS+1).
- IDLE: i_rx=0 at an edge (edge 0) -> START.
- START: at cnt=H-1 (edge H) sample i_rx: 0 -> DATA, idx=0; 1 -> IDLE (glitch rejected, no outputs).
- DATA: each time cnt=N-1, sample i_rx into shift register MSB, shift right; idx++. After DATA_BITS samples (edge H+DATA_BITS*N) -> STOP. Samples land at mid-bit.
- STOP: at cnt=N-1 (edge H+(DATA_BITS+1)*N) sample i_rx:
  1 -> deliver byte (see handshake), -> IDLE on same edge (back-to-back frames supported; next start bit may be seen on the following edge).
  0 -> o_frame_err=1 for one cycle, byte discarded, -> BREAK.
- BREAK: wait for i_rx=1, then -> IDLE. o_busy stays high.
- Handshake: delivery sets o_valid=1 and loads o_data on the stop-sample edge (N=16, 8 bits: edge 152). Transfer occurs on any edge with o_valid & i_ready; o_valid clears next edge unless a new byte is delivered on that same edge.
- Simultaneous delivery and acceptance: new byte loaded, o_valid stays 1, no overrun.
- Delivery with o_valid=1 and i_ready=0: new byte dropped, old o_data retained, o_overrun pulses one cycle.
- i_ready ignored while o_valid=0.

Optional Feature:
UART_RX_PARITY_EN: when defined, adds parameter PARITY_ODD (default 0 = even), state PARITY between DATA and STOP (one bit time, sampled at cnt=N-1) and output o_parity_err (1 bit). o_parity_err is loaded with o_data on delivery and held with it: 1 when XOR(data bits, parity bit) != PARITY_ODD. Byte is still delivered; stop sample moves to edge H+(DATA_BITS+2)*N. Without the macro: no PARITY state, no o_parity_err port, frame is start+data+stop only.

Test Plan:
1. Reset mid-byte: drop i_rst_n at edge 60 of a frame -> all outputs 0 immediately; release with i_rx=1 for 200 cycles -> o_valid never rises, o_busy=0.
2. Send 0xA5 (N=16, i_ready=1) -> o_valid high exactly one cycle from edge 152, o_data=0xA5, no error pulses.
3. Glitch: i_rx low 5 cycles then high -> START sample at edge 8 sees 1, back to IDLE; o_busy high edges 0-8 only, no o_valid.
4. Send 0x3C with stop bit 0, hold line low 40 cycles, then send 0x55 -> one o_frame_err pulse, no o_valid for 0x3C; o_valid with o_data=0x55 for second frame.
5. i_ready=0, send 0x11 then 0x22 back-to-back -> o_valid held with 0x11, one o_overrun pulse at 0x22's stop sample; raise i_ready -> 0x11 accepted, o_valid drops.
6. UART_RX_PARITY_EN, PARITY_ODD=0: send 0x07 with parity bit 0 -> o_valid with o_data=0x07, o_parity_err=1; with parity bit 1 -> o_parity_err=0.
